// File: rtl/br_rsv_station.sv
// Branch/JALR reservation station: CDB wakeup, one issue per cycle to cmp one cycle after an entry is ready.
// disp_ready drops when full and cmp_busy holds issue. Define BR_RS_AGE_ORDER_EN to issue the oldest ready entry.
module br_rsv_station #(
  parameter int RS_DEPTH  = 4,
  parameter int ROB_IDX_W = 6,
  parameter int BR_TAG_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic                         disp_cmp_type,
  input  logic [2:0]                   disp_cmp_op,
  input  logic [31:0]                  disp_imm,
  input  logic [31:0]                  disp_pc,
  input  logic [BR_TAG_W-1:0]          disp_br_tag,
  input  logic [ROB_IDX_W-1:0]         disp_rob_idx,
  input  logic                         disp_a_rdy,
  input  logic [ROB_IDX_W-1:0]         disp_a_tag,
  input  logic [31:0]                  disp_a_val,
  input  logic                         disp_b_rdy,
  input  logic [ROB_IDX_W-1:0]         disp_b_tag,
  input  logic [31:0]                  disp_b_val,
  input  logic                         cdb_valid,
  input  logic [ROB_IDX_W-1:0]         cdb_rob_idx,
  input  logic [31:0]                  cdb_data,
  input  logic                         cmp_busy,
  output logic                         issue_out,
  output logic                         issue_cmp_type,
  output logic [2:0]                   issue_cmp_op,
  output logic [31:0]                  issue_imm,
  output logic [31:0]                  issue_pc,
  output logic [BR_TAG_W-1:0]          issue_br_tag,
  output logic [ROB_IDX_W-1:0]         issue_rob_idx,
  output logic [31:0]                  issue_a,
  output logic [31:0]                  issue_b,
  output logic [$clog2(RS_DEPTH):0]    rs_count
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic                 valid;
    logic                 cmp_type;
    logic [2:0]           cmp_op;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic [BR_TAG_W-1:0]  br_tag;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 a_rdy;
    logic [ROB_IDX_W-1:0] a_tag;
    logic [31:0]          a_val;
    logic                 b_rdy;
    logic [ROB_IDX_W-1:0] b_tag;
    logic [31:0]          b_val;
`ifdef BR_RS_AGE_ORDER_EN
    logic [IDX_W-1:0]     age;
`endif
  } entry_t;

  entry_t              ent_q [RS_DEPTH];
  entry_t              ent_d [RS_DEPTH];
  entry_t              new_ent;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [RS_DEPTH-1:0] rdy_vec;
  logic                sel_vld, free_vld, issue, do_disp;
  logic [IDX_W-1:0]    sel_idx, free_idx;
`ifdef BR_RS_AGE_ORDER_EN
  logic [IDX_W-1:0]    best_age;
`endif

  assign disp_ready = (count_q < CNT_W'(RS_DEPTH));
  assign do_disp    = disp_valid && disp_ready && free_vld && !flush;
  assign issue      = sel_vld && !cmp_busy && !flush;
  assign rs_count   = count_q;

  // Selection looks only at registered state, so a CDB wakeup issues no earlier than the next cycle.
  always_comb begin
    rdy_vec  = '0;
    sel_vld  = 1'b0;
    sel_idx  = '0;
    free_vld = 1'b0;
    free_idx = '0;
`ifdef BR_RS_AGE_ORDER_EN
    best_age = '1;
`endif
    for (int i = 0; i < RS_DEPTH; i++) begin
      rdy_vec[i] = ent_q[i].valid && ent_q[i].a_rdy && ent_q[i].b_rdy;
      if (!ent_q[i].valid && !free_vld) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
`ifdef BR_RS_AGE_ORDER_EN
      if (rdy_vec[i] && (!sel_vld || ent_q[i].age < best_age)) begin
        sel_vld  = 1'b1;
        sel_idx  = IDX_W'(i);
        best_age = ent_q[i].age;
      end
`else
      if (rdy_vec[i] && !sel_vld) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
`endif
    end
  end

  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.cmp_type = disp_cmp_type;
    new_ent.cmp_op   = disp_cmp_op;
    new_ent.imm      = disp_imm;
    new_ent.pc       = disp_pc;
    new_ent.br_tag   = disp_br_tag;
    new_ent.rob_idx  = disp_rob_idx;
    new_ent.a_rdy    = disp_a_rdy;
    new_ent.a_tag    = disp_a_tag;
    new_ent.a_val    = disp_a_val;
    new_ent.b_rdy    = disp_b_rdy;
    new_ent.b_tag    = disp_b_tag;
    new_ent.b_val    = disp_b_val;
    if (!disp_a_rdy && cdb_valid && cdb_rob_idx == disp_a_tag) begin
      new_ent.a_rdy = 1'b1;
      new_ent.a_val = cdb_data;
    end
    if (!disp_b_rdy && cdb_valid && cdb_rob_idx == disp_b_tag) begin
      new_ent.b_rdy = 1'b1;
      new_ent.b_val = cdb_data;
    end
    // JALR has no second source; never let it wait on one.
    if (!disp_cmp_type) new_ent.b_rdy = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    if (do_disp && !issue)      count_d = count_q + 1'b1;
    else if (!do_disp && issue) count_d = count_q - 1'b1;
    if (flush) count_d = '0;
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid && cdb_valid) begin
        if (!ent_q[i].a_rdy && ent_q[i].a_tag == cdb_rob_idx) begin
          ent_d[i].a_rdy = 1'b1;
          ent_d[i].a_val = cdb_data;
        end
        if (!ent_q[i].b_rdy && ent_q[i].b_tag == cdb_rob_idx) begin
          ent_d[i].b_rdy = 1'b1;
          ent_d[i].b_val = cdb_data;
        end
      end
`ifdef BR_RS_AGE_ORDER_EN
      if (issue && ent_q[i].valid && ent_q[i].age > ent_q[sel_idx].age)
        ent_d[i].age = ent_q[i].age - 1'b1;
`endif
      if (issue && sel_idx == IDX_W'(i)) ent_d[i].valid = 1'b0;
      if (do_disp && free_idx == IDX_W'(i)) begin
        ent_d[i] = new_ent;
`ifdef BR_RS_AGE_ORDER_EN
        ent_d[i].age = IDX_W'(count_d - 1'b1);
`endif
      end
      if (flush) ent_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  always_comb begin
    issue_out      = issue;
    issue_cmp_type = 1'b0;
    issue_cmp_op   = '0;
    issue_imm      = '0;
    issue_pc       = '0;
    issue_br_tag   = '0;
    issue_rob_idx  = '0;
    issue_a        = '0;
    issue_b        = '0;
    if (issue) begin
      issue_cmp_type = ent_q[sel_idx].cmp_type;
      issue_cmp_op   = ent_q[sel_idx].cmp_op;
      issue_imm      = ent_q[sel_idx].imm;
      issue_pc       = ent_q[sel_idx].pc;
      issue_br_tag   = ent_q[sel_idx].br_tag;
      issue_rob_idx  = ent_q[sel_idx].rob_idx;
      issue_a        = ent_q[sel_idx].a_val;
      issue_b        = ent_q[sel_idx].b_val;
    end
  end

endmodule

// File: tb/tb_br_rsv_station.sv
// Bench for br_rsv_station: per-cycle vector table plus an issue scoreboard.
module tb_br_rsv_station;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush, disp_valid, disp_ready, disp_cmp_type;
  logic [2:0]  disp_cmp_op;
  logic [31:0] disp_imm, disp_pc;
  logic [3:0]  disp_br_tag;
  logic [5:0]  disp_rob_idx, disp_a_tag, disp_b_tag, cdb_rob_idx;
  logic        disp_a_rdy, disp_b_rdy, cdb_valid, cmp_busy;
  logic [31:0] disp_a_val, disp_b_val, cdb_data;
  logic        issue_out, issue_cmp_type;
  logic [2:0]  issue_cmp_op;
  logic [31:0] issue_imm, issue_pc, issue_a, issue_b;
  logic [3:0]  issue_br_tag;
  logic [5:0]  issue_rob_idx;
  logic [2:0]  rs_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  br_rsv_station dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_cmp_type(disp_cmp_type), .disp_cmp_op(disp_cmp_op),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_br_tag(disp_br_tag),
    .disp_rob_idx(disp_rob_idx),
    .disp_a_rdy(disp_a_rdy), .disp_a_tag(disp_a_tag), .disp_a_val(disp_a_val),
    .disp_b_rdy(disp_b_rdy), .disp_b_tag(disp_b_tag), .disp_b_val(disp_b_val),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
    .cmp_busy(cmp_busy),
    .issue_out(issue_out), .issue_cmp_type(issue_cmp_type), .issue_cmp_op(issue_cmp_op),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_br_tag(issue_br_tag),
    .issue_rob_idx(issue_rob_idx), .issue_a(issue_a), .issue_b(issue_b),
    .rs_count(rs_count)
  );

  typedef struct {
    int dv, ty, rob, ar, at, av, br, bt, bv, cv, ct, cd, busy, fl, push, ea, eb, e_iss, e_cnt;
  } vec_t;

  typedef struct {
    logic [5:0]  rob;
    logic        ty;
    logic [31:0] a, b;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[$];

  function automatic vec_t r(int dv, int ty, int rob, int ar, int at, int av, int br, int bt,
                             int bv, int cv, int ct, int cd, int busy, int fl, int push,
                             int ea, int eb, int e_iss, int e_cnt);
    vec_t v;
    v.dv = dv; v.ty = ty; v.rob = rob; v.ar = ar; v.at = at; v.av = av;
    v.br = br; v.bt = bt; v.bv = bv; v.cv = cv; v.ct = ct; v.cd = cd;
    v.busy = busy; v.fl = fl; v.push = push; v.ea = ea; v.eb = eb;
    v.e_iss = e_iss; v.e_cnt = e_cnt;
    return v;
  endfunction

  function automatic vec_t idl(int busy, int e_iss, int e_cnt);
    return r(0,0,0, 0,0,0, 0,0,0, 0,0,0, busy,0, 0,0,0, e_iss,e_cnt);
  endfunction

  function automatic vec_t cdb(int ct, int cd, int busy, int e_iss, int e_cnt);
    return r(0,0,0, 0,0,0, 0,0,0, 1,ct,cd, busy,0, 0,0,0, e_iss,e_cnt);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int rob, input int ty, input int a, input int b);
    exp_t e;
    e.rob = 6'(rob); e.ty = (ty != 0); e.a = 32'(a); e.b = 32'(b);
    sb.push_back(e);
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    disp_valid    = (v.dv != 0);
    disp_cmp_type = (v.ty != 0);
    disp_rob_idx  = 6'(v.rob);
    disp_cmp_op   = 3'(v.rob);
    disp_pc       = 32'h1000 + 32'(v.rob) * 32'd4;
    disp_imm      = 32'(v.rob) * 32'd3;
    disp_br_tag   = 4'(v.rob);
    disp_a_rdy    = (v.ar != 0); disp_a_tag = 6'(v.at); disp_a_val = 32'(v.av);
    disp_b_rdy    = (v.br != 0); disp_b_tag = 6'(v.bt); disp_b_val = 32'(v.bv);
    cdb_valid     = (v.cv != 0); cdb_rob_idx = 6'(v.ct); cdb_data = 32'(v.cd);
    cmp_busy      = (v.busy != 0);
    flush         = (v.fl != 0);
    if (v.push != 0) push_exp(v.rob, v.ty, v.ea, v.eb);
    @(negedge clk);
    check("issue_out", 32'(issue_out), 32'(v.e_iss));
    check("rs_count", 32'(rs_count), 32'(v.e_cnt));
    check("disp_ready", 32'(disp_ready), (v.e_cnt < 4) ? 32'd1 : 32'd0);
  endtask

  // Every issue strobe must match the next expected op in order.
  always @(negedge clk) begin
    if (!rst && issue_out) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_issue actual_rob=%0d required=none", issue_rob_idx);
      end else begin
        mon_e = sb.pop_front();
        check("issue_rob_idx", 32'(issue_rob_idx), 32'(mon_e.rob));
        check("issue_cmp_type", 32'(issue_cmp_type), 32'(mon_e.ty));
        check("issue_cmp_op", 32'(issue_cmp_op), 32'(mon_e.rob[2:0]));
        check("issue_pc", issue_pc, 32'h1000 + 32'(mon_e.rob) * 32'd4);
        check("issue_imm", issue_imm, 32'(mon_e.rob) * 32'd3);
        check("issue_br_tag", 32'(issue_br_tag), 32'(mon_e.rob[3:0]));
        check("issue_a", issue_a, mon_e.a);
        check("issue_b", issue_b, mon_e.b);
      end
    end
  end

  initial begin
    flush = 1'b0; disp_valid = 1'b0; disp_cmp_type = 1'b0; disp_cmp_op = '0;
    disp_imm = '0; disp_pc = '0; disp_br_tag = '0; disp_rob_idx = '0;
    disp_a_rdy = 1'b0; disp_a_tag = '0; disp_a_val = '0;
    disp_b_rdy = 1'b0; disp_b_tag = '0; disp_b_val = '0;
    cdb_valid = 1'b0; cdb_rob_idx = '0; cdb_data = '0; cmp_busy = 1'b0;

    // beq with both operands ready
    tbl.push_back(r(1,1,7, 1,0,5, 1,0,5, 0,0,0, 0,0, 1,5,5, 0,0));
    tbl.push_back(idl(0,1,1));
    tbl.push_back(idl(0,0,0));
    // bne waiting on tag 3, woken two cycles later
    tbl.push_back(r(1,1,8, 0,3,0, 1,0,1, 0,0,0, 0,0, 1,'h10,1, 0,0));
    tbl.push_back(idl(0,0,1));
    tbl.push_back(cdb(3,'h10,0,0,1));
    tbl.push_back(idl(0,1,1));
    tbl.push_back(idl(0,0,0));
    // fill all four entries, then a dropped fifth dispatch
    for (int k = 0; k < 4; k++)
      tbl.push_back(r(1,1,10+k, 0,20+k,0, 1,0,k, 0,0,0, 0,0, 0,0,0, 0,k));
    tbl.push_back(r(1,1,14, 1,0,9, 1,0,9, 0,0,0, 0,0, 0,0,0, 0,4));
    tbl.push_back(idl(0,0,4));
    // wake rob 11 while cmp is busy for three cycles
    tbl.push_back(r(0,1,11, 0,0,0, 0,0,0, 1,21,'h55, 1,0, 1,'h55,1, 0,4));
    tbl.push_back(idl(1,0,4));
    tbl.push_back(idl(1,0,4));
    tbl.push_back(idl(1,0,4));
    tbl.push_back(idl(0,1,4));
    tbl.push_back(idl(0,0,3));
    // one ready entry, then flush together with a CDB and a dispatch
    tbl.push_back(cdb(22,'h77,0,0,3));
    tbl.push_back(r(1,1,15, 1,0,1, 1,0,1, 1,20,'h66, 0,1, 0,0,0, 0,3));
    tbl.push_back(idl(0,0,0));
    // JALR with same-cycle CDB forwarding and an unused b operand
    tbl.push_back(r(1,0,16, 0,30,0, 0,31,0, 1,30,'h1234, 0,0, 1,'h1234,0, 0,0));
    tbl.push_back(idl(0,1,1));
    tbl.push_back(idl(0,0,0));
    // dispatch and issue in one cycle keep the count
    tbl.push_back(r(1,1,17, 1,0,1, 1,0,2, 0,0,0, 0,0, 1,1,2, 0,0));
    tbl.push_back(r(1,1,18, 1,0,3, 1,0,4, 0,0,0, 0,0, 1,3,4, 1,1));
    tbl.push_back(idl(0,1,1));
    tbl.push_back(idl(0,0,0));
    // both operands wake on one broadcast
    tbl.push_back(r(1,1,19, 0,40,0, 0,40,0, 0,0,0, 0,0, 1,'hAB,'hAB, 0,0));
    tbl.push_back(cdb(40,'hAB,0,0,1));
    tbl.push_back(idl(0,1,1));
    tbl.push_back(idl(0,0,0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_disp_ready", 32'(disp_ready), 32'd1);
    check("reset_issue_out", 32'(issue_out), 32'd0);
    check("reset_rs_count", 32'(rs_count), 32'd0);
    check("reset_issue_a", issue_a, 32'd0);
    check("reset_issue_rob_idx", 32'(issue_rob_idx), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Entry 0 refilled after entry 2, both woken while busy: order shows the issue policy.
    apply(r(1,1,20, 1,0,'h20, 1,0,'h21, 0,0,0, 1,0, 1,'h20,'h21, 0,0));
    apply(r(1,1,21, 0,51,0, 1,0,7, 0,0,0, 1,0, 0,0,0, 0,1));
    apply(r(1,0,22, 0,52,0, 0,0,0, 0,0,0, 1,0, 0,0,0, 0,2));
    apply(idl(0,1,3));
    apply(r(1,1,23, 0,53,0, 1,0,8, 0,0,0, 1,0, 0,0,0, 0,2));
`ifdef BR_RS_AGE_ORDER_EN
    push_exp(22, 0, 'h200, 0);
    push_exp(23, 1, 'h300, 8);
`else
    push_exp(23, 1, 'h300, 8);
    push_exp(22, 0, 'h200, 0);
`endif
    apply(cdb(53,'h300,1,0,3));
    apply(cdb(52,'h200,1,0,3));
    apply(idl(0,1,3));
    apply(idl(0,1,2));
    apply(r(0,1,21, 0,0,0, 0,0,0, 1,51,'h100, 0,0, 1,'h100,7, 0,1));
    apply(idl(0,1,1));
    apply(idl(0,0,0));

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
